// File: rtl/sift_pkg.sv
// rtl/sift_pkg.sv - shared widths, keypoint record and merge FSM states
package sift_pkg;

   localparam int ROW_W  = 9;
   localparam int COL_W  = 10;
   localparam int KP_W   = ROW_W + COL_W;
   localparam int ADDR_W = 11;
   localparam int CNT_W  = 12;

   typedef struct packed {
      logic [ROW_W-1:0] row;
      logic [COL_W-1:0] col;
   } kp_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_MERGE,
      ST_FIN
   } state_e;

   // Raster order: row is the major key, column breaks ties within a row.
   function automatic logic kp_le(input kp_t a, input kp_t b);
      return {a.row, a.col} <= {b.row, b.col};
   endfunction

endpackage

// File: rtl/kp_list_reader.sv
// rtl/kp_list_reader.sv - walks one keypoint SRAM list, keeping one prefetched head entry
module kp_list_reader
   import sift_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              init_i,
   input  logic              fetch_i,
   input  logic              pop_i,
   input  logic [CNT_W-1:0]  count_i,
   input  logic [KP_W-1:0]   dout_i,
   output logic [ADDR_W-1:0] addr_o,
   output kp_t               head_o,
   output logic              head_vld_o,
   output logic              exhausted_o,
   output logic              final_o
);

   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  ptr_q;
   logic [CNT_W-1:0]  ptr_d;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] addr_d;
   logic              pend_q;
   logic              head_vld_q;
   kp_t               head_q;
   logic              issue;

   // The refill address goes out in the pop cycle itself so a list can sustain one entry per two cycles.
   always_comb begin
      ptr_d  = ptr_q;
      addr_d = addr_q;
      issue  = 1'b0;
      if (init_i) begin
         ptr_d = '0;
      end else if (fetch_i) begin
         issue = (count_q != '0);
         if (issue) addr_d = '0;
      end else if (pop_i) begin
         ptr_d = ptr_q + 1'b1;
         issue = (ptr_d < count_q);
         if (issue) addr_d = ptr_d[ADDR_W-1:0];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q    <= '0;
         ptr_q      <= '0;
         addr_q     <= '0;
         pend_q     <= 1'b0;
         head_vld_q <= 1'b0;
         head_q     <= '0;
      end else begin
         ptr_q  <= ptr_d;
         addr_q <= addr_d;
         pend_q <= issue;
         if (pend_q) begin
            head_q     <= kp_t'(dout_i);
            head_vld_q <= 1'b1;
         end else if (pop_i) begin
            head_vld_q <= 1'b0;
         end
         if (init_i) begin
            count_q    <= count_i;
            pend_q     <= 1'b0;
            head_vld_q <= 1'b0;
         end
      end
   end

   assign addr_o      = addr_d;
   assign head_o      = head_q;
   assign head_vld_o  = head_vld_q;
   assign exhausted_o = (ptr_q == count_q) && !head_vld_q;
   assign final_o     = ((ptr_q + 1'b1) == count_q);

endmodule

// File: rtl/keypoint_merge_dispatch.sv
// rtl/keypoint_merge_dispatch.sv - merges the two scale keypoint lists into one raster-ordered stream
module keypoint_merge_dispatch
   import sift_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  kp1_count,
   input  logic [CNT_W-1:0]  kp2_count,
   output logic [ADDR_W-1:0] kp1_addr,
   input  logic [KP_W-1:0]   kp1_dout,
   output logic [ADDR_W-1:0] kp2_addr,
   input  logic [KP_W-1:0]   kp2_dout,
   output logic              kp_valid,
   input  logic              kp_ready,
   output logic [KP_W-1:0]   kp_data,
   output logic              kp_scale,
   output logic              kp_last,
   output logic              busy,
   output logic              done
);

   state_e state_q, state_d;

   logic init, fetch, merge;
   kp_t  head1, head2;
   logic hv1, hv2, ex1, ex2, fin1, fin2;
   logic pop1, pop2;
   logic out_free, sel_ok, pick2, sel_last;
   kp_t  sel_head;

   logic out_vld_q, out_scale_q, out_last_q, done_q;
   kp_t  out_data_q;

   assign init  = (state_q == ST_IDLE) && start;
   assign fetch = (state_q == ST_FETCH);
   assign merge = (state_q == ST_MERGE);

   kp_list_reader u_list1 (
      .clk_i       (clk),
      .rst_i       (rst),
      .init_i      (init),
      .fetch_i     (fetch),
      .pop_i       (pop1),
      .count_i     (kp1_count),
      .dout_i      (kp1_dout),
      .addr_o      (kp1_addr),
      .head_o      (head1),
      .head_vld_o  (hv1),
      .exhausted_o (ex1),
      .final_o     (fin1)
   );

   kp_list_reader u_list2 (
      .clk_i       (clk),
      .rst_i       (rst),
      .init_i      (init),
      .fetch_i     (fetch),
      .pop_i       (pop2),
      .count_i     (kp2_count),
      .dout_i      (kp2_dout),
      .addr_o      (kp2_addr),
      .head_o      (head2),
      .head_vld_o  (hv2),
      .exhausted_o (ex2),
      .final_o     (fin2)
   );

   // A list still waiting on its refill blocks selection so order is never decided on a stale head.
   always_comb begin
      out_free = !out_vld_q || kp_ready;
      sel_ok   = merge && out_free && (ex1 || hv1) && (ex2 || hv2) && !(ex1 && ex2);
      pick2    = ex1 || (!ex2 && !kp_le(head1, head2));
      pop1     = sel_ok && !pick2;
      pop2     = sel_ok && pick2;
      sel_head = pick2 ? head2 : head1;
      sel_last = pick2 ? (fin2 && ex1) : (fin1 && ex2);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_FETCH;
         ST_FETCH: state_d = (ex1 && ex2) ? ST_FIN : ST_MERGE;
         ST_MERGE: if (out_vld_q && out_last_q && kp_ready) state_d = ST_FIN;
         ST_FIN:   state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= (state_q == ST_FIN);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_vld_q   <= 1'b0;
         out_data_q  <= '0;
         out_scale_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else if (sel_ok) begin
         out_vld_q   <= 1'b1;
         out_data_q  <= sel_head;
         out_scale_q <= pick2;
         out_last_q  <= sel_last;
      end else if (kp_ready) begin
         out_vld_q   <= 1'b0;
      end
   end

   assign kp_valid = out_vld_q;
   assign kp_data  = out_data_q;
   assign kp_scale = out_scale_q;
   assign kp_last  = out_last_q;
   assign busy     = (state_q != ST_IDLE);
   assign done     = done_q;

endmodule

// File: tb/tb_keypoint_merge_dispatch.sv
// tb/tb_keypoint_merge_dispatch.sv - directed bench for the keypoint merge/dispatch block
module tb_keypoint_merge_dispatch;
   import sift_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [CNT_W-1:0]  kp1_count, kp2_count;
   logic [ADDR_W-1:0] kp1_addr, kp2_addr;
   logic [KP_W-1:0]   kp1_dout, kp2_dout;
   logic              kp_valid, kp_ready, kp_scale, kp_last, busy, done;
   logic [KP_W-1:0]   kp_data;

   logic [KP_W-1:0] mem1 [2048];
   logic [KP_W-1:0] mem2 [2048];

   int vectors = 0;
   int miscompares = 0;

   logic [20:0] got_q[$];
   logic [20:0] exp_q[$];
   int done_cnt, done_cyc, stall_err, wrap_err, valid_seen, busy1;
   bit finished;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      kp1_dout <= mem1[kp1_addr];
      kp2_dout <= mem2[kp2_addr];
   end

   keypoint_merge_dispatch dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .kp1_count (kp1_count),
      .kp2_count (kp2_count),
      .kp1_addr  (kp1_addr),
      .kp1_dout  (kp1_dout),
      .kp2_addr  (kp2_addr),
      .kp2_dout  (kp2_dout),
      .kp_valid  (kp_valid),
      .kp_ready  (kp_ready),
      .kp_data   (kp_data),
      .kp_scale  (kp_scale),
      .kp_last   (kp_last),
      .busy      (busy),
      .done      (done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [18:0] kp(input int r, input int c);
      return {r[8:0], c[9:0]};
   endfunction

   function automatic logic [20:0] ent(input int r, input int c, input bit s, input bit l);
      return {l, s, kp(r, c)};
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < 2048; i++) begin
         mem1[i] = '0;
         mem2[i] = '0;
      end
   endtask

   // rmode 0: always ready; rmode 1: ready pattern 1,0,0,1 repeating
   task automatic run(input int n1, input int n2, input int rmode, input int budget);
      logic        prev_stall;
      logic [20:0] stall_v;
      logic [20:0] cur;
      bit          left_zero;
      got_q.delete();
      done_cnt = 0; done_cyc = -1; stall_err = 0; wrap_err = 0;
      valid_seen = 0; busy1 = 0; finished = 0;
      prev_stall = 1'b0; stall_v = '0; left_zero = 0;
      @(negedge clk);
      kp1_count = n1[CNT_W-1:0];
      kp2_count = n2[CNT_W-1:0];
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 1; cyc <= budget && !finished; cyc++) begin
         if (rmode == 1) kp_ready = ((cyc % 4) == 2 || (cyc % 4) == 3) ? 1'b0 : 1'b1;
         else            kp_ready = 1'b1;
         #1;
         cur = {kp_last, kp_scale, kp_data};
         if (cyc == 1) busy1 = busy;
         if (kp_valid) valid_seen = 1;
         if (prev_stall && (!kp_valid || cur != stall_v)) stall_err++;
         if (kp_valid && kp_ready) got_q.push_back(cur);
         prev_stall = kp_valid && !kp_ready;
         stall_v = cur;
         if (kp1_addr != '0) left_zero = 1;
         else if (left_zero) wrap_err++;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            finished = 1;
         end
         @(negedge clk);
      end
      check("run_completed", finished, 1);
      check("done_one_cycle", done, 0);
   endtask

   task automatic expect_stream(input string tag);
      check({tag, "_len"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         if (i < got_q.size()) check($sformatf("%s_elem%0d", tag, i), got_q[i], exp_q[i]);
   endtask

   initial begin
      int hs;
      int late_done;
      rst = 1'b1; start = 1'b0; kp_ready = 1'b0;
      kp1_count = '0; kp2_count = '0;
      clear_mem();
      repeat (3) @(negedge clk);
      check("rst_kp_valid", kp_valid, 0);
      check("rst_kp_data", kp_data, 0);
      check("rst_kp_scale_last", {kp_scale, kp_last}, 0);
      check("rst_busy_done", {busy, done}, 0);
      check("rst_addrs", {kp1_addr, kp2_addr}, 0);
      rst = 1'b0;

      // 1: basic interleave
      mem1[0] = kp(2, 5); mem1[1] = kp(4, 1); mem2[0] = kp(3, 7);
      run(2, 1, 0, 200);
      exp_q = '{ent(2, 5, 0, 0), ent(3, 7, 1, 0), ent(4, 1, 0, 1)};
      expect_stream("t1");
      check("t1_done_cnt", done_cnt, 1);
      check("t1_busy_after_start", busy1, 1);
      check("t1_busy_after_done", busy, 0);

      // 2: tie goes to scale 1 list first
      mem1[0] = kp(10, 10); mem2[0] = kp(10, 10);
      run(1, 1, 0, 200);
      exp_q = '{ent(10, 10, 0, 0), ent(10, 10, 1, 1)};
      expect_stream("t2");

      // 3: both lists empty
      run(0, 0, 0, 50);
      check("t3_no_valid", valid_seen, 0);
      check("t3_done_cycle", done_cyc, 3);

      // 4: single list under back-pressure
      mem1[0] = kp(1, 1); mem1[1] = kp(1, 9); mem1[2] = kp(2, 0);
      mem1[3] = kp(7, 3); mem1[4] = kp(8, 8);
      run(5, 0, 1, 300);
      exp_q = '{ent(1, 1, 0, 0), ent(1, 9, 0, 0), ent(2, 0, 0, 0), ent(7, 3, 0, 0), ent(8, 8, 0, 1)};
      expect_stream("t4");
      check("t4_stall_stable", stall_err, 0);

      // 5: full 2048-entry list
      exp_q.delete();
      for (int i = 0; i < 2048; i++) begin
         mem1[i] = 19'(i * 200 + 3);
         exp_q.push_back({(i == 2047), 1'b0, 19'(i * 200 + 3)});
      end
      run(2048, 0, 0, 6000);
      expect_stream("t5");
      check("t5_no_early_wrap", wrap_err, 0);
      check("t5_addr_holds", kp1_addr, 2047);

      // 6: reset during third transfer, then a clean rerun
      clear_mem();
      mem1[0] = kp(0, 3); mem1[1] = kp(5, 5); mem1[2] = kp(9, 1);
      mem2[0] = kp(1, 2); mem2[1] = kp(5, 5);
      @(negedge clk);
      kp1_count = 3; kp2_count = 2; start = 1'b1; kp_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      hs = 0;
      for (int cyc = 0; cyc < 200 && hs < 3; cyc++) begin
         #1;
         if (kp_valid && kp_ready) begin
            hs++;
            if (hs == 3) begin
               check("t6_third_elem", {kp_last, kp_scale, kp_data}, ent(5, 5, 0, 0));
               rst = 1'b1;
            end
         end
         @(negedge clk);
      end
      check("t6_reached_third", hs, 3);
      check("t6_rst_valid", kp_valid, 0);
      check("t6_rst_outputs", {kp_data, kp_scale, kp_last, busy, done}, 0);
      check("t6_rst_addrs", {kp1_addr, kp2_addr}, 0);
      rst = 1'b0;
      late_done = 0;
      repeat (6) begin
         @(negedge clk);
         if (done || kp_valid) late_done++;
      end
      check("t6_abandoned_quiet", late_done, 0);
      run(3, 2, 0, 200);
      exp_q = '{ent(0, 3, 0, 0), ent(1, 2, 1, 0), ent(5, 5, 0, 0), ent(5, 5, 1, 0), ent(9, 1, 0, 1)};
      expect_stream("t6_rerun");
      check("t6_rerun_done", done_cnt, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
